// File: rtl/v810_exc_seq.sv
// Exception-entry sequencer: saves PC/PSW, updates ECR/PSW through the sysreg port, returns the handler vector.
// Optional macro V810_EXC_INTLVL_EN raises PSW.I to EXC_LVL+1 on maskable interrupts.
module v810_exc_seq #(
  parameter logic [15:0] VEC_BASE = 16'hFFFF
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  input  logic        EXC_REQ,
  input  logic [15:0] EXC_CODE,
  input  logic [31:0] EXC_PC,
  input  logic        EXC_IRQ,
  input  logic [3:0]  EXC_LVL,
  output logic        ACK,
  output logic [31:0] VECTOR,
  output logic        BUSY,
  output logic        FATAL,
  output logic [4:0]  RA,
  input  logic [31:0] RD,
  output logic [4:0]  WA,
  output logic [31:0] WD,
  output logic        WE
);

  localparam logic [4:0] REG_EIPC  = 5'd0;
  localparam logic [4:0] REG_EIPSW = 5'd1;
  localparam logic [4:0] REG_FEPC  = 5'd2;
  localparam logic [4:0] REG_FEPSW = 5'd3;
  localparam logic [4:0] REG_ECR   = 5'd4;
  localparam logic [4:0] REG_PSW   = 5'd5;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_RD_PSW = 4'd1,
    S_RD_ECR = 4'd2,
    S_WR_PC  = 4'd3,
    S_WR_PSV = 4'd4,
    S_WR_ECR = 4'd5,
    S_WR_PSW = 4'd6,
    S_DONE   = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] psw_q, psw_d, ecr_q, ecr_d, pc_q, pc_d;
  logic [15:0] code_q, code_d;
  logic        dup_q, dup_d;
  logic [4:0]  ra_q, ra_d, wa_q, wa_d;
  logic [31:0] wd_q, wd_d, vector_q, vector_d;
  logic        we_q, we_d, ack_q, ack_d, busy_q, busy_d, fatal_q, fatal_d;
  logic [31:0] psw_new_s;

`ifdef V810_EXC_INTLVL_EN
  logic        irq_q, irq_d;
  logic [3:0]  lvl_q, lvl_d;
`else
  logic        unused_intlvl_s;
  assign unused_intlvl_s = ^{EXC_IRQ, EXC_LVL};
`endif

  // PSW value written on entry: ID set, AE cleared, EP or NP raised depending on nesting.
  always_comb begin
    psw_new_s     = psw_q;
    psw_new_s[12] = 1'b1;
    psw_new_s[13] = 1'b0;
    if (dup_q) begin
      psw_new_s[15] = 1'b1;
    end else begin
      psw_new_s[14] = 1'b1;
    end
`ifdef V810_EXC_INTLVL_EN
    if (irq_q) begin
      psw_new_s[19:16] = (lvl_q == 4'd15) ? 4'd15 : (lvl_q + 4'd1);
    end else begin
      psw_new_s[19:16] = psw_q[19:16];
    end
`endif
  end

  // Next-state logic and next values of the registered sysreg-port outputs.
  always_comb begin
    state_d = state_q;
    psw_d   = psw_q;
    ecr_d   = ecr_q;
    pc_d    = pc_q;
    code_d  = code_q;
    dup_d   = dup_q;
`ifdef V810_EXC_INTLVL_EN
    irq_d   = irq_q;
    lvl_d   = lvl_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (EXC_REQ) begin
          code_d  = EXC_CODE;
          pc_d    = EXC_PC;
`ifdef V810_EXC_INTLVL_EN
          irq_d   = EXC_IRQ;
          lvl_d   = EXC_LVL;
`endif
          state_d = S_RD_PSW;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_PSW: begin
        psw_d   = RD;
        dup_d   = RD[14];
        state_d = RD[15] ? S_HALT : S_RD_ECR;
      end
      S_RD_ECR: begin
        ecr_d   = RD;
        state_d = S_WR_PC;
      end
      S_WR_PC:  state_d = S_WR_PSV;
      S_WR_PSV: state_d = S_WR_ECR;
      S_WR_ECR: state_d = S_WR_PSW;
      S_WR_PSW: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase

    // Outputs are decoded from the state being entered so they are registered yet aligned with it.
    ra_d     = ra_q;
    wa_d     = wa_q;
    wd_d     = wd_q;
    vector_d = vector_q;
    we_d     = 1'b0;
    ack_d    = 1'b0;
    busy_d   = (state_d != S_IDLE);
    fatal_d  = fatal_q | (state_d == S_HALT);
    case (state_d)
      S_RD_PSW: ra_d = REG_PSW;
      S_RD_ECR: ra_d = REG_ECR;
      S_WR_PC: begin
        we_d = 1'b1;
        wa_d = dup_q ? REG_FEPC : REG_EIPC;
        wd_d = pc_q;
      end
      S_WR_PSV: begin
        we_d = 1'b1;
        wa_d = dup_q ? REG_FEPSW : REG_EIPSW;
        wd_d = psw_q;
      end
      S_WR_ECR: begin
        we_d = 1'b1;
        wa_d = REG_ECR;
        wd_d = dup_q ? {code_q, ecr_q[15:0]} : {ecr_q[31:16], code_q};
      end
      S_WR_PSW: begin
        we_d = 1'b1;
        wa_d = REG_PSW;
        wd_d = psw_new_s;
      end
      S_DONE: begin
        ack_d    = 1'b1;
        vector_d = {VEC_BASE, code_q[15:4], 4'h0};
      end
      default: begin
      end
    endcase
  end

  // State, captured operands and output registers; everything freezes when CE is low.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q  <= S_IDLE;
      psw_q    <= 32'h0;
      ecr_q    <= 32'h0;
      pc_q     <= 32'h0;
      code_q   <= 16'h0;
      dup_q    <= 1'b0;
      ra_q     <= 5'd0;
      wa_q     <= 5'd0;
      wd_q     <= 32'h0;
      vector_q <= 32'h0;
      we_q     <= 1'b0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      fatal_q  <= 1'b0;
`ifdef V810_EXC_INTLVL_EN
      irq_q    <= 1'b0;
      lvl_q    <= 4'd0;
`endif
    end else if (CE) begin
      state_q  <= state_d;
      psw_q    <= psw_d;
      ecr_q    <= ecr_d;
      pc_q     <= pc_d;
      code_q   <= code_d;
      dup_q    <= dup_d;
      ra_q     <= ra_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      vector_q <= vector_d;
      we_q     <= we_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      fatal_q  <= fatal_d;
`ifdef V810_EXC_INTLVL_EN
      irq_q    <= irq_d;
      lvl_q    <= lvl_d;
`endif
    end
  end

  // The strobe is qualified so a held write never lands on a non-CE edge or during reset.
  assign WE     = we_q & CE & ~RES;
  assign ACK    = ack_q;
  assign VECTOR = vector_q;
  assign BUSY   = busy_q;
  assign FATAL  = fatal_q;
  assign RA     = ra_q;
  assign WA     = wa_q;
  assign WD     = wd_q;

endmodule

// File: doc/v810_exc_seq.md
Name: v810_exc_seq

Overview:
- Exception-entry sequencer and initiator side of the system-register read/write port.
- On an exception or interrupt request it reads PSW and ECR, then saves PC/PSW into EIPC/EIPSW or FEPC/FEPSW.
- It then writes the exception code into ECR, updates PSW, and hands the handler vector back to the fetch stage.
- Sits between the pipeline's exception detect logic and v810_sysreg. While BUSY is high it owns RA/WA/WD/WE.

Parameters:
- VEC_BASE, 16'hFFFF, upper half of every handler vector.

Ports:
- CLK  in  1  clock.
- RES  in  1  reset, synchronous, active-high.
- CE  in  1  global clock enable. State advances only on CE cycles.
- EXC_REQ  in  1  exception request. Level, held until ACK.
- EXC_CODE  in  16  exception code (ECR format).
- EXC_PC  in  32  restart PC to save.
- EXC_IRQ  in  1  request is a maskable interrupt.
- EXC_LVL  in  4  interrupt level (valid with EXC_IRQ).
- ACK  out  1  one-CE-cycle pulse: sequence complete, VECTOR valid.
- VECTOR  out  32  handler address.
- BUSY  out  1  sequencer owns sysreg port.
- FATAL  out  1  sticky: exception taken with PSW.NP=1.
- RA  out  5  sysreg read address.
- RD  in  32  sysreg read data (combinational from RA).
- WA  out  5  sysreg write address.
- WD  out  32  sysreg write data.
- WE  out  1  sysreg write strobe.

Behaviour:
- Register numbers: EIPC=0, EIPSW=1, FEPC=2, FEPSW=3, ECR=4, PSW=5.
- PSW bits: ID=12, AE=13, EP=14, NP=15, I=19:16.
- Reset (RES high on a CE edge): state IDLE. ACK=0, BUSY=0, FATAL=0, WE=0, VECTOR=0, RA=0, WA=0, WD=0.
- RES mid-sequence aborts immediately. No further writes occur.
- State machine. Every state except IDLE and HALT lasts exactly one CE cycle.
  - IDLE: BUSY=0. If EXC_REQ, latch code/PC/IRQ/LVL and go RD_PSW.
  - RD_PSW: RA=PSW. Capture RD as psw_s.
    - psw_s.NP=1 -> HALT.
    - psw_s.EP=1 -> dup=1.
    - else dup=0.
    - Go RD_ECR.
  - RD_ECR: RA=ECR. Capture ecr_s. Go WR_PC.
  - WR_PC: WE=1, WA = dup ? FEPC : EIPC, WD=EXC_PC. Go WR_PSV.
  - WR_PSV: WE=1, WA = dup ? FEPSW : EIPSW, WD=psw_s. Go WR_ECR.
  - WR_ECR: WE=1, WA=ECR.
    - dup: WD = {EXC_CODE, ecr_s[15:0]}.
    - else: WD = {ecr_s[31:16], EXC_CODE}.
    - Go WR_PSW.
  - WR_PSW: WE=1, WA=PSW, WD = psw_s with ID=1 and AE=0.
    - dup: NP=1.
    - else: EP=1.
    - Go DONE.
  - DONE: ACK=1, BUSY=1, VECTOR = {VEC_BASE, EXC_CODE[15:4], 4'h0}. Go IDLE.
  - HALT: FATAL=1, BUSY=1, ACK never asserts. Left only via RES.
- BUSY=1 in every state except IDLE.
- WE=1 only in the WR_* states and only on CE cycles. WD/WA are held stable across non-CE cycles.
- Latency from EXC_REQ sampled in IDLE to ACK: 7 CE cycles. Writes occur on CE cycles 4-7.
- EXC_REQ still high in the cycle after ACK starts a new sequence. The requester must drop EXC_REQ on ACK.
- Latched inputs are immune to changes during the sequence.
- The sysreg's own ALU-flag updates may race PSW. The pipeline must hold flag set/reset at 0 while BUSY.
- CE low: all state, outputs and captured registers freeze.

Optional Feature:
- Macro: V810_EXC_INTLVL_EN.
- Enabled, with EXC_IRQ=1 in WR_PSW:
  - PSW.I = EXC_LVL+1, saturating at 15.
  - Sequences with EXC_IRQ=1 and psw_s.EP=1 are still saved duplexed.
- Disabled: PSW.I is copied unchanged from psw_s, and EXC_IRQ/EXC_LVL are ignored (may be unconnected).

Test Plan:
- Normal entry: PSW=0x00000000, ECR=0x12340000, EXC_CODE=0xFF60, EXC_PC=0x07000100.
  - Expect EIPC=0x07000100, EIPSW=0, ECR=0x1234FF60, PSW=0x00005000.
  - Expect ACK on 7th CE cycle, VECTOR=0xFFFFFF60.
- Duplexed: PSW=0x00004000, ECR=0x0000FF60, code 0xFFA0.
  - Expect FEPC=PC, FEPSW=0x00004000, ECR=0xFFA0FF60, PSW=0x0000D000.
  - EIPC/EIPSW are untouched.
- Fatal: PSW=0x00008000 (reset value), EXC_REQ.
  - Expect no WE ever, FATAL=1 and BUSY=1 after 2 CE cycles, ACK=0.
  - RES clears FATAL.
- CE throttling: CE toggled 1/0 every cycle during normal entry.
  - Expect 7 CE cycles to ACK (14 clocks) and identical writes.
  - WE is never asserted on CE=0.
- Reset mid-sequence: RES asserted in WR_ECR.
  - Expect no PSW write, outputs at reset values next cycle, BUSY=0.
- Interrupt (V810_EXC_INTLVL_EN): EXC_IRQ=1, EXC_LVL=4, PSW.I=2 -> PSW.I=5.
  - EXC_LVL=15 -> PSW.I=15.
  - With macro off -> PSW.I stays 2.
